// File: rtl/nonrestoring_divider.sv
// nonrestoring_divider: sequential radix-2 non-restoring divider, one iteration per clock, start/busy/done handshake.
// Define NRDIV_SIGNED_EN for two's-complement operands; otherwise operands and results are unsigned.
module nonrestoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  typedef enum logic [1:0] {IDLE, ITER, CORR, DONE} state_t;
  localparam int CW = $clog2(WIDTH + 1);
  state_t state, state_nx;
  logic [WIDTH:0] p, p_sh, p_it, p_fix;
  logic [WIDTH-1:0] q, d, num, a_mag, d_mag, q_res, r_res;
  logic [CW-1:0] cnt;
  logic accept;
`ifdef NRDIV_SIGNED_EN
  logic sa, sd;
  assign a_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign d_mag = divisor[WIDTH-1] ? -divisor : divisor;
  assign q_res = (sa ^ sd) ? -q : q;
  assign r_res = sa ? -p_fix[WIDTH-1:0] : p_fix[WIDTH-1:0];
`else
  assign a_mag = dividend;
  assign d_mag = divisor;
  assign q_res = q;
  assign r_res = p_fix[WIDTH-1:0];
`endif
  assign accept = start && (state == IDLE || state == DONE);
  assign p_sh   = {p[WIDTH-1:0], q[WIDTH-1]};
  // P may only be out of range transiently in p_sh; the add/sub result always fits WIDTH+1 bits
  assign p_it   = p[WIDTH] ? p_sh + {1'b0, d} : p_sh - {1'b0, d};
  assign p_fix  = p[WIDTH] ? p + {1'b0, d} : p;
  assign busy   = state == ITER || state == CORR;
  assign done   = state == DONE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? ITER : IDLE;
      ITER:    state_nx = cnt == CW'(1) ? CORR : ITER;
      CORR:    state_nx = DONE;
      default: state_nx = start ? ITER : IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      p           <= '0;
      q           <= '0;
      d           <= '0;
      num         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef NRDIV_SIGNED_EN
      sa          <= 1'b0;
      sd          <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (accept) begin
        p   <= '0;
        q   <= a_mag;
        d   <= d_mag;
        num <= dividend;
        cnt <= CW'(WIDTH);
`ifdef NRDIV_SIGNED_EN
        sa  <= dividend[WIDTH-1];
        sd  <= divisor[WIDTH-1];
`endif
      end else if (state == ITER) begin
        p   <= p_it;
        q   <= {q[WIDTH-2:0], ~p_it[WIDTH]};
        cnt <= cnt - CW'(1);
      end else if (state == CORR) begin
        p           <= p_fix;
        quotient    <= d == '0 ? '1 : q_res;
        remainder   <= d == '0 ? num : r_res;
        div_by_zero <= d == '0;
      end
    end
  end
endmodule

// File: tb/tb_nonrestoring_divider.sv
// tb_nonrestoring_divider: scoreboard bench with directed vectors for both signed and unsigned builds.
module tb_nonrestoring_divider;
  localparam int W = 8;
  logic clk = 0, rst_n = 0, start = 0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  typedef struct {logic [W-1:0] q; logic [W-1:0] r; logic z; int cyc;} exp_t;
  exp_t sb[$];
  int total = 0, bad = 0, cyc = 0;

  nonrestoring_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got done=1 want no result pending (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", div_by_zero, e.z);
        chk("latency_cycle", cyc, e.cyc);
        chk("busy_at_done", busy, 0);
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] eq,
                       input logic [W-1:0] er, input logic ez);
    @(negedge clk);
    start = 1;
    dividend = a;
    divisor = b;
    sb.push_back('{eq, er, ez, cyc + W + 2});
    @(negedge clk);
    start = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_quotient"}, quotient, 0);
    chk({tag, "_remainder"}, remainder, 0);
    chk({tag, "_dbz"}, div_by_zero, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1;
`ifdef NRDIV_SIGNED_EN
    issue(8'd100, 8'd7, 8'h0E, 8'h02, 0); drain();
    issue(8'h9C, 8'd7, 8'hF2, 8'hFE, 0); drain();
    issue(8'd100, 8'hF9, 8'hF2, 8'h02, 0); drain();
    issue(8'h80, 8'hFF, 8'h80, 8'h00, 0); drain();
    issue(8'h80, 8'h01, 8'h80, 8'h00, 0); drain();
    issue(8'h7F, 8'h80, 8'h00, 8'h7F, 0); drain();
    issue(8'd5, 8'd0, 8'hFF, 8'h05, 1); drain();
    issue(8'd9, 8'd3, 8'h03, 8'h00, 0); drain();
`else
    issue(8'd200, 8'd7, 8'd28, 8'd4, 0); drain();
    issue(8'd255, 8'd1, 8'd255, 8'd0, 0); drain();
    issue(8'd13, 8'd0, 8'hFF, 8'd13, 1); drain();
    issue(8'd9, 8'd3, 8'd3, 8'd0, 0); drain();
    issue(8'd100, 8'd7, 8'd14, 8'd2, 0); drain();
`endif
    // start held through ITER with other operands must be ignored
    @(negedge clk);
    start = 1;
    dividend = 8'd100;
    divisor = 8'd7;
    sb.push_back('{8'd14, 8'd2, 1'b0, cyc + W + 2});
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      dividend = 8'd1 + 8'(i);
      divisor = 8'd1;
    end
    start = 0;
    drain();
    // back-to-back accept in the DONE cycle
    issue(8'd9, 8'd3, 8'd3, 8'd0, 0);
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    chk("b2b_first_done", done, 1);
    start = 1;
    dividend = 8'd50;
    divisor = 8'd6;
    sb.push_back('{8'd8, 8'd2, 1'b0, cyc + W + 2});
    @(negedge clk);
    start = 0;
    drain();
    // asynchronous abort mid-iteration
    issue(8'd50, 8'd6, 8'd8, 8'd2, 0);
    repeat (3) @(negedge clk);
    chk("pre_abort_busy", busy, 1);
    rst_n = 0;
    #1;
    chk_zero("abort");
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    issue(8'd50, 8'd6, 8'd8, 8'd2, 0); drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nonrestoring_divider.md
Name: nonrestoring_divider

Overview:
Sequential radix-2 non-restoring divider. It is the inverse-operation companion to the team's combinational Booth multiplier, and it uses the same two's-complement operand conventions.
- One iteration per clock.
- Start/busy/done handshake.
- Sits beside the multiplier in the arithmetic datapath.
- Checking rule: for any non-zero divisor, the identity dividend = quotient*divisor + remainder must hold when the quotient is fed back through the multiplier.

Parameters:
WIDTH, 8, operand and result width in bits (WIDTH >= 2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only when state is IDLE or DONE
dividend  input  WIDTH  numerator, sampled on the accepting edge
divisor  input  WIDTH  denominator, sampled on the accepting edge
busy  output  1  high while a division is in progress (ITER or CORR)
done  output  1  one-cycle pulse; quotient/remainder valid
quotient  output  WIDTH  result quotient
remainder  output  WIDTH  result remainder
div_by_zero  output  1  flag for the completed operation; valid with done, held until next accept

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, internal registers=0.
- Reset mid-operation: asserting rst_n low aborts immediately to the reset values. No partial result is ever presented.
- States:
  - IDLE: start=1 captures the magnitudes of the operands and their sign bits, clears the partial remainder P (WIDTH+1 bits, signed), and loads the iteration counter with WIDTH. Next state is ITER.
  - ITER: each cycle, shift {P,Q} left by 1.
    - If P was non-negative: P = P - |divisor|.
    - If P was negative: P = P + |divisor|.
    - The new Q LSB is the inverse of the new P sign bit.
    - Decrement the counter. After WIDTH iterations, next state is CORR.
  - CORR: if P is negative, P = P + |divisor| (remainder restore). Apply the sign fix:
    - quotient negated when sign(dividend) XOR sign(divisor).
    - remainder negated when the dividend is negative.
    - Results are registered. Next state is DONE.
  - DONE: done=1 for exactly one cycle, busy=0. With start=1, a new operation is accepted (back-to-back) and the next state is ITER; otherwise the next state is IDLE.
- Latency: with start sampled at edge k, done is high in the cycle following edge k+WIDTH+1. Latency is constant at WIDTH+2 edges for every operand pair, including divide-by-zero.
- start asserted while busy=1 is ignored. Operand inputs are don't-care outside the accepting edge.
- quotient, remainder and div_by_zero hold their values from DONE until the next completed operation. They do not change during ITER/CORR.
- Arithmetic: truncation toward zero. The remainder takes the sign of the dividend, and |remainder| < |divisor|.
- Overflow: most-negative / -1 gives quotient = most-negative (wraps), remainder = 0, no flag.
- Divisor = 0: the iterations still run, and the outputs are forced in CORR: quotient = all ones, remainder = dividend, div_by_zero = 1.
- Magnitude of the most-negative operand: it is handled as the unsigned value 2^(WIDTH-1). The magnitude registers are WIDTH bits unsigned, and P is WIDTH+1 bits, so it does not overflow.

Optional Feature:
NRDIV_SIGNED_EN
- Defined: two's-complement signed division, as described above.
- Undefined: operands and results are unsigned. The abs/sign-fix logic is removed, and the overflow case does not exist. Divide-by-zero gives quotient = all ones, remainder = dividend, div_by_zero = 1. Latency is unchanged (WIDTH+2).

Test Plan:
- Signed build, WIDTH=8, start with 100 / 7 -> done after 10 edges: quotient=14 (0x0E), remainder=2, div_by_zero=0. -100 / 7 -> quotient=0xF2 (-14), remainder=0xFE (-2). 100 / -7 -> 0xF2, 0x02.
- -128 / -1 -> quotient=0x80, remainder=0x00, div_by_zero=0. -128 / 1 -> 0x80, 0x00. 127 / -128 -> 0x00, 0x7F.
- 5 / 0 -> quotient=0xFF, remainder=0x05, div_by_zero=1 after 10 edges. The next op, 9 / 3, returns 3, 0, div_by_zero=0.
- Handshake: start held high during ITER with different operands -> ignored, first result unaffected. start=1 in the DONE cycle -> second op accepted; its done arrives 10 edges later with no idle gap.
- Reset: drop rst_n at iteration 4 of 50 / 6 -> busy, done and outputs go to 0 immediately. After release, 50 / 6 returns 8, 2.
- Unsigned build (NRDIV_SIGNED_EN undefined): 200 / 7 -> quotient=28, remainder=4. 255 / 1 -> 255, 0. 13 / 0 -> 0xFF, 13, div_by_zero=1.
